// File: rtl/irq_request_latch.sv
// Request latch ahead of the 8-to-3 priority encoder: sticky pending bits, mask, ack-clear, overflow.
// Define IRQ_REQ_SYNC_EN to pass req_in through a 2-flop synchroniser per line.
module irq_request_latch #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  input  logic             edge_mode,
  input  logic             glb_en,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  output logic [N-1:0]     pend,
  output logic             enc_en,
  output logic             irq,
  output logic [N-1:0]     ovf
);

  localparam logic [N-1:0] OneHot0 = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] req_s;
  logic [N-1:0] req_prev_q;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] ovf_q, ovf_d;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] ovf_set;

`ifdef IRQ_REQ_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= req_in;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = req_in;
`endif

  always_comb begin
    set_vec = edge_mode ? (req_s & ~req_prev_q) : req_s;
    // Indices >= N shift out of the vector, so out-of-range acks clear nothing.
    clr_vec = ack ? (OneHot0 << ack_idx) : '0;
    // Set wins over a same-cycle clear, so a fresh request is never lost.
    pend_d  = set_vec | (pend_q & ~clr_vec);
    ovf_set = edge_mode ? (set_vec & pend_q & ~clr_vec) : '0;
    ovf_d   = ovf_set | (ovf_q & ~clr_vec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_prev_q <= '0;
      pend_q     <= '0;
      ovf_q      <= '0;
    end else begin
      req_prev_q <= req_s;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pend   = pend_q & ~mask;
  assign enc_en = glb_en;
  assign irq    = glb_en & (|pend);
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Scoreboard bench for irq_request_latch (default build, no input synchroniser).
module tb_irq_request_latch;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       edge_mode;
  logic       glb_en;
  logic       ack;
  logic [2:0] ack_idx;
  logic [7:0] pend;
  logic       enc_en;
  logic       irq;
  logic [7:0] ovf;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] pend;
    logic       irq;
    logic [7:0] ovf;
    logic       en;
  } exp_t;

  exp_t sb_q[$];

  irq_request_latch #(
    .N    (8),
    .IDX_W(3)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .mask     (mask),
    .edge_mode(edge_mode),
    .glb_en   (glb_en),
    .ack      (ack),
    .ack_idx  (ack_idx),
    .pend     (pend),
    .enc_en   (enc_en),
    .irq      (irq),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] p, input logic i,
                          input logic [7:0] o);
    exp_t e;
    e.tag  = tag;
    e.pend = p;
    e.irq  = i;
    e.ovf  = o;
    e.en   = glb_en;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check_val({e.tag, ".pend"}, 32'(pend), 32'(e.pend));
    check_val({e.tag, ".irq"}, 32'(irq), 32'(e.irq));
    check_val({e.tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
    check_val({e.tag, ".enc_en"}, 32'(enc_en), 32'(e.en));
  endtask

  // Clocked step: expectation is for the outputs just after the next rising edge.
  task automatic step(input string tag, input logic [7:0] p, input logic i, input logic [7:0] o);
    push_exp(tag, p, i, o);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  // Combinational step: outputs must respond without a clock edge.
  task automatic settle(input string tag, input logic [7:0] p, input logic i,
                        input logic [7:0] o);
    push_exp(tag, p, i, o);
    #1;
    pop_cmp();
  endtask

  task automatic do_ack(input string tag, input logic [2:0] idx, input logic [7:0] p,
                        input logic [7:0] o);
    ack     = 1'b1;
    ack_idx = idx;
    step(tag, p, glb_en & (|p), o);
    ack     = 1'b0;
  endtask

  initial begin
    logic [7:0] ones;
    rst       = 1'b0;
    req_in    = 8'hFF;
    mask      = 8'h00;
    edge_mode = 1'b1;
    glb_en    = 1'b1;
    ack       = 1'b0;
    ack_idx   = 3'd0;
    #1 rst = 1'b1;
    #2;

    // 1. reset, then a line already high is seen as an edge
    settle("reset", 8'h00, 1'b0, 8'h00);
    step("reset_held", 8'h00, 1'b0, 8'h00);
    rst = 1'b0;
    step("rel_edge", 8'hFF, 1'b1, 8'h00);
    step("hold_high", 8'hFF, 1'b1, 8'h00);
    req_in = 8'h00;
    ones   = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] e;
      e = ones << (k + 1);
      do_ack($sformatf("drain%0d", k), 3'(k), e, 8'h00);
    end

    // 2. edge capture and ack
    req_in = 8'h21;
    step("pulse", 8'h21, 1'b1, 8'h00);
    req_in = 8'h00;
    do_ack("ack5", 3'd5, 8'h01, 8'h00);
    do_ack("ack0", 3'd0, 8'h00, 8'h00);

    // 3. overflow and set-wins
    req_in = 8'h04;
    step("l2_first", 8'h04, 1'b1, 8'h00);
    req_in = 8'h00;
    step("l2_low", 8'h04, 1'b1, 8'h00);
    req_in = 8'h04;
    step("l2_ovf", 8'h04, 1'b1, 8'h04);
    req_in = 8'h10;
    do_ack("set_wins", 3'd4, 8'h14, 8'h04);
    req_in = 8'h00;
    do_ack("ack_nonpend", 3'd3, 8'h14, 8'h04);
    do_ack("ack2_clr_ovf", 3'd2, 8'h10, 8'h00);
    do_ack("ack4", 3'd4, 8'h00, 8'h00);

    // 4. level mode
    edge_mode = 1'b0;
    req_in    = 8'h80;
    step("lvl_set", 8'h80, 1'b1, 8'h00);
    step("lvl_hold", 8'h80, 1'b1, 8'h00);
    do_ack("lvl_repend", 3'd7, 8'h80, 8'h00);
    req_in = 8'h00;
    do_ack("lvl_clear", 3'd7, 8'h00, 8'h00);
    edge_mode = 1'b1;

    // 5. mask and global enable
    mask   = 8'hF0;
    req_in = 8'hA4;
    step("masked", 8'h04, 1'b1, 8'h00);
    req_in = 8'h00;
    mask   = 8'h00;
    settle("unmask", 8'hA4, 1'b1, 8'h00);
    glb_en = 1'b0;
    settle("gen_off", 8'hA4, 1'b0, 8'h00);
    req_in = 8'h01;
    step("latch_while_off", 8'hA5, 1'b0, 8'h00);
    req_in = 8'h00;
    glb_en = 1'b1;
    settle("gen_on", 8'hA5, 1'b1, 8'h00);
    do_ack("clr0", 3'd0, 8'hA4, 8'h00);
    do_ack("clr2", 3'd2, 8'hA0, 8'h00);
    do_ack("clr5", 3'd5, 8'h80, 8'h00);
    do_ack("clr7", 3'd7, 8'h00, 8'h00);

    // 6. async reset mid-operation
    req_in = 8'hC0;
    step("c0_set", 8'hC0, 1'b1, 8'h00);
    req_in = 8'h00;
    step("c0_low", 8'hC0, 1'b1, 8'h00);
    req_in = 8'h40;
    step("c0_ovf", 8'hC0, 1'b1, 8'h40);
    #2 rst = 1'b1;
    settle("async_rst", 8'h00, 1'b0, 8'h00);
    @(posedge clk);
    #3 rst = 1'b0;
    step("post_rst_edge", 8'h40, 1'b1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
